// File: rtl/dmem_responder.sv
// Data-memory target for CPU loads/stores: valid/ready request and response
// channels, programmable wait states, byte-lane write strobes, error responses.
// Only one transaction is in flight at a time.
module dmem_responder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       LATENCY   = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_wdata;
  logic [3:0]          lat_wstrb;

  logic [31:0]         mem [DEPTH];

  logic                accept_c;
  logic                access_c;
  logic                acc_write_c;
  logic [ADDR_W-1:0]   acc_addr_c;
  logic [31:0]         acc_wdata_c;
  logic [3:0]          acc_wstrb_c;
  logic [ADDR_W-1:0]   offset_c;
  logic                err_c;
  logic [IDX_W-1:0]    idx_c;
  logic [31:0]         rd_word_c;
  logic [31:0]         resp_data_c;

  // Access decode: with zero wait states the live request is used on the accept edge
  always_comb begin
    accept_c    = req_valid && req_ready;
    access_c    = ((state == S_IDLE) && accept_c && (LATENCY == 0)) ||
                  ((state == S_WAIT) && (cnt == CNT_W'(1)));
    acc_write_c = lat_write;
    acc_addr_c  = lat_addr;
    acc_wdata_c = lat_wdata;
    acc_wstrb_c = lat_wstrb;
    if (state == S_IDLE) begin
      acc_write_c = req_write;
      acc_addr_c  = req_addr;
      acc_wdata_c = req_wdata;
      acc_wstrb_c = req_wstrb;
    end
    // Addresses below BASE_ADDR wrap to large offsets and so fail the range test
    offset_c    = acc_addr_c - BASE_ADDR;
    err_c       = (acc_addr_c[1:0] != 2'b00) || ((offset_c >> 2) >= ADDR_W'(DEPTH));
    idx_c       = offset_c[IDX_W+1:2];
    rd_word_c   = mem[idx_c];
    resp_data_c = (err_c || acc_write_c) ? 32'h0 : rd_word_c;
  end

  // Storage: byte-lane writes on the commit edge; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && access_c && acc_write_c && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb_c[i]) begin
          mem[idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= 32'h0;
      lat_wstrb  <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            cnt       <= CNT_W'(LATENCY);
            req_ready <= 1'b0;
            if (LATENCY == 0) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= resp_data_c;
              resp_err   <= err_c;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= resp_data_c;
            resp_err   <= err_c;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
